// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns PC_IF, keeps at most one imem request in flight,
// queues returned instructions in a small buffer and drives the IF/ID pipeline register.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = 32'h0000_0013,
    parameter int unsigned     FB_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PC_EN_IF,
    input  logic            reg_FD_EN,
    input  logic            reg_FD_stall,
    input  logic            reg_FD_flush,
    input  logic            Branch_ID,
    input  logic [XLEN-1:0] PC_branch_ID,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] PC_ID,
    output logic [XLEN-1:0] inst_ID,
    output logic            valid_ID,
    output logic            fetch_starve
);

    localparam int unsigned PTR_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FB_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FB_DEPTH - 1);
    localparam logic [CNT_W-1:0] FB_FULL  = CNT_W'(FB_DEPTH);
    localparam logic [OCC_W-1:0] OCC_LIM  = OCC_W'(FB_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            kill_q, kill_d;

    logic [XLEN-1:0] fb_pc_q   [FB_DEPTH];
    logic [XLEN-1:0] fb_inst_q [FB_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] fb_count_q, fb_count_d;

    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [XLEN-1:0] inst_id_q, inst_id_d;
    logic            valid_id_q, valid_id_d;
    logic            starve_q, starve_d;

    logic            redirect_s;
    logic            advance_s;
    logic            fb_empty_s;
    logic            fb_pop_s;
    logic            rsp_in_s;
    logic            rsp_push_s;
    logic            fb_clear_s;
    logic            fb_wr_s;
    logic [OCC_W-1:0] occ_s;
    logic            credit_ok_s;
    logic            req_valid_s;
    logic            accept_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_W'(1'b1));
    endfunction

    // A held load-use stall suppresses the redirect; decode re-presents the branch later.
    assign redirect_s  = Branch_ID & PC_EN_IF;
    assign advance_s   = reg_FD_EN & ~reg_FD_stall & ~reg_FD_flush;
    assign fb_empty_s  = (fb_count_q == {CNT_W{1'b0}});
    assign fb_pop_s    = advance_s & ~fb_empty_s;
    assign rsp_in_s    = imem_rsp_valid & (state_q == S_WAIT);
    assign rsp_push_s  = rsp_in_s & ~kill_q;
    assign fb_clear_s  = redirect_s | reg_FD_flush;
    assign fb_wr_s     = rsp_push_s & ~fb_clear_s;

    // Occupancy at end of cycle; a new request is only issued if its reply is sure to fit.
    assign occ_s       = OCC_W'(fb_count_q) - OCC_W'(fb_pop_s) + OCC_W'(rsp_push_s);
    assign credit_ok_s = (occ_s < OCC_LIM);
    assign req_valid_s = PC_EN_IF & (state_q != S_IDLE) & ((state_q == S_REQ) | imem_rsp_valid)
                       & credit_ok_s & ~redirect_s;
    assign accept_s    = req_valid_s & imem_req_ready;

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign PC_ID          = pc_id_q;
    assign inst_ID        = inst_id_q;
    assign valid_ID       = valid_id_q;
    assign fetch_starve   = starve_q;

    // Request FSM, PC sequencing and kill tracking for the outstanding request.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        kill_d   = kill_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (accept_s) state_d = S_WAIT;
                else          state_d = S_REQ;
            end
            S_WAIT: begin
                if (imem_rsp_valid) state_d = accept_s ? S_WAIT : S_REQ;
                else                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_s)    pc_d = PC_branch_ID;
        else if (accept_s) pc_d = pc_q + XLEN'(3'd4);
        else               pc_d = pc_q;
        if (accept_s) out_pc_d = pc_q;
        else          out_pc_d = out_pc_q;
        if (redirect_s)    kill_d = (state_q == S_WAIT) & ~imem_rsp_valid;
        else if (rsp_in_s) kill_d = 1'b0;
        else               kill_d = kill_q;
    end

    // Fetch-buffer pointers and occupancy.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fb_count_d = fb_count_q;
        if (fb_clear_s) begin
            rd_ptr_d   = {PTR_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
            fb_count_d = {CNT_W{1'b0}};
        end else begin
            if (fb_pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
            else          rd_ptr_d = rd_ptr_q;
            if (fb_wr_s)  wr_ptr_d = ptr_inc(wr_ptr_q);
            else          wr_ptr_d = wr_ptr_q;
            if (fb_pop_s && !fb_wr_s)      fb_count_d = fb_count_q - CNT_W'(1'b1);
            else if (!fb_pop_s && fb_wr_s) fb_count_d = fb_count_q + CNT_W'(1'b1);
            else                           fb_count_d = fb_count_q;
        end
    end

    // IF/ID register next state; bubbles carry PC 0 and a NOP.
    always_comb begin
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        starve_d   = 1'b0;
        if (!reg_FD_EN) begin
            starve_d = 1'b0;
        end else if (reg_FD_flush) begin
            pc_id_d    = {XLEN{1'b0}};
            inst_id_d  = NOP;
            valid_id_d = 1'b0;
        end else if (reg_FD_stall) begin
            starve_d = 1'b0;
        end else if (!fb_empty_s) begin
            pc_id_d    = fb_pc_q[rd_ptr_q];
            inst_id_d  = fb_inst_q[rd_ptr_q];
            valid_id_d = 1'b1;
        end else begin
            pc_id_d    = {XLEN{1'b0}};
            inst_id_d  = NOP;
            valid_id_d = 1'b0;
            starve_d   = 1'b1;
        end
    end

    // Control and pipeline-register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            out_pc_q   <= {XLEN{1'b0}};
            kill_q     <= 1'b0;
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            fb_count_q <= {CNT_W{1'b0}};
            pc_id_q    <= {XLEN{1'b0}};
            inst_id_q  <= NOP;
            valid_id_q <= 1'b0;
            starve_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_pc_q   <= out_pc_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fb_count_q <= fb_count_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
            starve_q   <= starve_d;
        end
    end

    // Fetch-buffer storage, written at the tail with the PC of the returning request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FB_DEPTH); i++) begin
                fb_pc_q[i]   <= {XLEN{1'b0}};
                fb_inst_q[i] <= NOP;
            end
        end else if (fb_wr_s) begin
            fb_pc_q[wr_ptr_q]   <= out_pc_q;
            fb_inst_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    // Issue credit must make a push into a full buffer without a pop impossible.
    fb_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fb_wr_s && !fb_pop_s && (fb_count_q == FB_FULL)));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: an imem responder with variable latency plus a
// queue-based reference model of fetch, redirect and the IF/ID register.
module tb_if_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP_C = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_EN_IF = 1'b0, reg_FD_EN = 1'b0, reg_FD_stall = 1'b0, reg_FD_flush = 1'b0;
    logic        Branch_ID = 1'b0;
    logic [31:0] PC_branch_ID = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] PC_ID, inst_ID;
    logic        valid_ID, fetch_starve;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush), .Branch_ID(Branch_ID),
        .PC_branch_ID(PC_branch_ID), .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .PC_ID(PC_ID), .inst_ID(inst_ID), .valid_ID(valid_ID), .fetch_starve(fetch_starve)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle time %0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: program counter, one in-flight request, instruction queue, IF/ID.
    logic [31:0] m_pc, m_out_pc, m_pc_id, m_inst_id;
    bit          m_warm, m_out, m_kill, m_valid_id, m_starve;
    logic [63:0] m_fb[$];

    // Memory side: single pending reply due in a given cycle.
    bit          im_pend = 1'b0;
    int          im_due = 0;
    logic [31:0] im_addr = 32'h0;
    int          cyc = 0;

    task automatic model_reset();
        m_pc = 32'h0; m_out_pc = 32'h0; m_pc_id = 32'h0; m_inst_id = NOP_C;
        m_warm = 1'b0; m_out = 1'b0; m_kill = 1'b0; m_valid_id = 1'b0; m_starve = 1'b0;
        m_fb.delete();
    endtask

    task automatic run_cycle(input bit en, input bit fd_en, input bit stall, input bit flush,
                             input bit br, input logic [31:0] tgt, input bit rdy, input int lat);
        bit rsp, redirect, adv, pop, push, exp_req, acc;
        logic [63:0] head;
        logic [31:0] issue_pc;
        int occ;
        PC_EN_IF = en; reg_FD_EN = fd_en; reg_FD_stall = stall; reg_FD_flush = flush;
        Branch_ID = br; PC_branch_ID = tgt; imem_req_ready = rdy;
        rsp = im_pend && (im_due == cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? inst_of(im_addr) : 32'hDEAD_BEEF;
        acc = 1'b0;
        issue_pc = m_pc;
        @(negedge clk);
        if (rst_n) begin
            redirect = br && en;
            adv = fd_en && !stall && !flush;
            pop = adv && (m_fb.size() > 0);
            push = rsp && m_out && !m_kill;
            occ = m_fb.size() - (pop ? 1 : 0) + (push ? 1 : 0);
            exp_req = en && m_warm && (!m_out || rsp) && (occ < DEPTH) && !redirect;
            chk_eq("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req});
            if (exp_req) chk_eq("req_addr", imem_req_addr, m_pc);
            chk_eq("PC_ID", PC_ID, m_pc_id);
            chk_eq("inst_ID", inst_ID, m_inst_id);
            chk_eq("valid_ID", {31'h0, valid_ID}, {31'h0, m_valid_id});
            chk_eq("fetch_starve", {31'h0, fetch_starve}, {31'h0, m_starve});
            acc = exp_req && rdy;
            m_starve = 1'b0;
            if (fd_en) begin
                if (flush) begin
                    m_pc_id = 32'h0; m_inst_id = NOP_C; m_valid_id = 1'b0;
                end else if (!stall) begin
                    if (pop) begin
                        head = m_fb[0];
                        m_pc_id = head[63:32]; m_inst_id = head[31:0]; m_valid_id = 1'b1;
                    end else begin
                        m_pc_id = 32'h0; m_inst_id = NOP_C; m_valid_id = 1'b0; m_starve = 1'b1;
                    end
                end
            end
            if (pop) void'(m_fb.pop_front());
            if (push) m_fb.push_back({m_out_pc, imem_rsp_data});
            if (redirect || flush) m_fb.delete();
            if (redirect) m_kill = m_out && !rsp;
            else if (rsp && m_out) m_kill = 1'b0;
            if (rsp && m_out) m_out = 1'b0;
            if (acc) begin m_out = 1'b1; m_out_pc = m_pc; end
            if (redirect) m_pc = tgt;
            else if (acc) m_pc = m_pc + 32'd4;
            m_warm = 1'b1;
        end else begin
            chk_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
            chk_eq("rst_PC_ID", PC_ID, 32'h0);
            chk_eq("rst_inst_ID", inst_ID, NOP_C);
            chk_eq("rst_valid_ID", {31'h0, valid_ID}, 32'h0);
            chk_eq("rst_fetch_starve", {31'h0, fetch_starve}, 32'h0);
        end
        if (rsp) im_pend = 1'b0;
        if (acc) begin im_pend = 1'b1; im_due = cyc + lat; im_addr = issue_pc; end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_plain(input int n, input int lat);
        for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, lat);
    endtask

    initial begin
        model_reset();
        repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5);
        rst_n = 1'b1;
        // Get a slow request in flight, then reset underneath it.
        run_plain(2, 5);
        rst_n = 1'b0;
        model_reset();
        repeat (3) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        rst_n = 1'b1;
        // Back-to-back stream with single-cycle memory.
        run_plain(10, 1);
        // Redirect while a request is in flight with no reply this cycle.
        for (int i = 0; i < 4; i++) begin
            if (m_out && !(im_pend && (im_due == cyc))) break;
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2);
        end
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 2);
        run_plain(6, 1);
        // Load-use freeze together with IF/ID stall.
        repeat (2) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        run_plain(4, 1);
        // Slow memory starves decode.
        run_plain(12, 3);
        // Branch during load-use freeze must be ignored.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1);
        run_plain(4, 1);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1);
        run_plain(4, 1);
        // Randomized mix of all controls.
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(99) < 90, $urandom_range(99) < 95, $urandom_range(99) < 15,
                      $urandom_range(99) < 5, $urandom_range(99) < 5, $urandom & 32'h0000_FFFC,
                      $urandom_range(99) < 70, int'($urandom_range(3, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
